// File: rtl/gf2m_sched.sv
// gf2m_sched: two-requester round-robin front end for a shared digit-serial GF(2^m) multiplier core.
// Latency: grant edge, then ITER+1 feed cycles, then 0..TIMEOUT wait cycles, then the response is held until accepted.
// Backpressure: a response stays valid until the owning requester asserts rsp_ready_i; no new grant happens until then.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   req_i[1:0]                        level requests, held until granted
//   a0_i/g0_i/b0_i, a1_i/g1_i/b1_i    per-requester operands (b is MSB-digit first)
//   gnt_o[1:0]                        one-cycle grant pulse (cycle after operands are sampled)
//   rsp_valid_o, rsp_ready_i          per-requester response handshake
//   rsp_t_o, rsp_err_o                result and timeout flag, qualified by rsp_valid_o
//   busy_o                            high whenever the scheduler is not idle
//   core_start_o, core_a_o, core_g_o, core_b_o, core_t_i, core_done_i   shared core interface
module gf2m_sched #(
    parameter int DIGITAL    = 16,
    parameter int DATA_WIDTH = 163,
    parameter int TIMEOUT    = 64,
    localparam int ITER      = DATA_WIDTH / DIGITAL,
    localparam int BWIDTH    = (ITER + 1) * DIGITAL
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            req_i,
    input  logic [DATA_WIDTH-1:0] a0_i,
    input  logic [DATA_WIDTH-1:0] g0_i,
    input  logic [BWIDTH-1:0]     b0_i,
    input  logic [DATA_WIDTH-1:0] a1_i,
    input  logic [DATA_WIDTH-1:0] g1_i,
    input  logic [BWIDTH-1:0]     b1_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rsp_valid_o,
    input  logic [1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_t_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  core_start_o,
    output logic [DATA_WIDTH-1:0] core_a_o,
    output logic [DATA_WIDTH-1:0] core_g_o,
    output logic [DIGITAL-1:0]    core_b_o,
    input  logic [DATA_WIDTH-1:0] core_t_i,
    input  logic                  core_done_i
);

    localparam int FCW = $clog2(ITER + 1);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [FCW-1:0] FEED_LAST = FCW'(ITER);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FEED = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    owner_q;
    logic                    prio_q;       // requester that wins a tie
    logic [FCW-1:0]          feed_cnt_q;
    logic [WCW-1:0]          wait_cnt_q;
    logic                    done_seen_q;  // core finished while digits were still being fed
    logic [BWIDTH-1:0]       bsh_q;
    logic [1:0]              gnt_q;
    logic [1:0]              rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_t_q;
    logic                    rsp_err_q;
    logic                    core_start_q;
    logic [DATA_WIDTH-1:0]   core_a_q;
    logic [DATA_WIDTH-1:0]   core_g_q;

    logic                    win_d;
    logic [1:0]              owner_oh;

    // A lone request always wins; the priority pointer only breaks ties.
    always_comb begin
        win_d = 1'b0;
        case (req_i)
            2'b10:   win_d = 1'b1;
            2'b11:   win_d = prio_q;
            default: win_d = 1'b0;
        endcase
    end

    assign owner_oh = owner_q ? 2'b10 : 2'b01;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            prio_q       <= 1'b0;
            feed_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            done_seen_q  <= 1'b0;
            bsh_q        <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_t_q      <= '0;
            rsp_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_a_q     <= '0;
            core_g_q     <= '0;
        end else begin
            gnt_q        <= '0;
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req_i) begin
                        owner_q      <= win_d;
                        prio_q       <= ~win_d;
                        gnt_q        <= win_d ? 2'b10 : 2'b01;
                        core_a_q     <= win_d ? a1_i : a0_i;
                        core_g_q     <= win_d ? g1_i : g0_i;
                        bsh_q        <= win_d ? b1_i : b0_i;
                        core_start_q <= 1'b1;
                        feed_cnt_q   <= '0;
                        done_seen_q  <= 1'b0;
                        state_q      <= S_FEED;
                    end
                end
                S_FEED: begin
                    bsh_q      <= bsh_q << DIGITAL;
                    feed_cnt_q <= feed_cnt_q + FCW'(1);
                    // An early completion is parked in rsp_t_q so WAIT can be skipped.
                    if (core_done_i && !done_seen_q) begin
                        rsp_t_q     <= core_t_i;
                        done_seen_q <= 1'b1;
                    end
                    if (feed_cnt_q == FEED_LAST) begin
                        wait_cnt_q <= '0;
                        if (done_seen_q || core_done_i) begin
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= owner_oh;
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (core_done_i) begin
                        rsp_t_q     <= core_t_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= owner_oh;
                        state_q     <= S_RESP;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        rsp_t_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= owner_oh;
                        state_q     <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WCW'(1);
                    end
                end
                S_RESP: begin
                    // Only the owner's ready counts; the other requester cannot retire this result.
                    if (rsp_ready_i[owner_q]) begin
                        rsp_valid_q <= '0;
                        core_a_q    <= '0;
                        core_g_q    <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_o        = gnt_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_t_o      = rsp_t_q;
    assign rsp_err_o    = rsp_err_q;
    assign busy_o       = (state_q != S_IDLE);
    assign core_start_o = core_start_q;
    assign core_a_o     = core_a_q;
    assign core_g_o     = core_g_q;
    assign core_b_o     = (state_q == S_FEED) ? bsh_q[BWIDTH-1 -: DIGITAL] : '0;

endmodule

// File: tb/tb_gf2m_sched.sv
// tb_gf2m_sched: directed bench for gf2m_sched with a transaction-level reference model.
// Latency: not applicable (bench).
// Backpressure: the bench plays both requesters and a stub core with a programmable completion time.
module tb_gf2m_sched;

    localparam int D  = 16;
    localparam int DW = 163;
    localparam int TO = 64;
    localparam int IT = DW / D;
    localparam int BW = (IT + 1) * D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [DW-1:0] a0, g0, a1, g1;
    logic [BW-1:0] b0, b1;
    logic [1:0]    rsp_ready = 2'b00;
    logic          core_done = 1'b0;
    logic [DW-1:0] core_t = '0;

    logic [1:0]    gnt_o, rsp_valid_o;
    logic [DW-1:0] rsp_t_o, core_a_o, core_g_o;
    logic          rsp_err_o, busy_o, core_start_o;
    logic [D-1:0]  core_b_o;

    gf2m_sched #(.DIGITAL(D), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req),
        .a0_i(a0), .g0_i(g0), .b0_i(b0), .a1_i(a1), .g1_i(g1), .b1_i(b1),
        .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_t_o(rsp_t_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .core_start_o(core_start_o), .core_a_o(core_a_o), .core_g_o(core_g_o),
        .core_b_o(core_b_o), .core_t_i(core_t), .core_done_i(core_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one transaction, tracked by its age in cycles since the grant edge.
    logic          m_active = 1'b0, m_resp = 1'b0, m_got = 1'b0, m_err = 1'b0;
    logic          m_owner = 1'b0, m_prio = 1'b0;
    int            m_age = 0;
    logic [BW-1:0] m_b = '0;
    logic [DW-1:0] m_a = '0, m_g = '0, m_t = '0;

    // Bench-side requesters, stub core and logs.
    int            req_left [2] = '{0, 0};
    int            stub_age = -1, stub_target = -1;
    logic [DW-1:0] stub_t = '0;
    logic          auto_ready = 1'b1;
    logic [1:0]    man_ready = 2'b00;
    int            gcnt = 0, start_cnt = 0, rsp_age = -1;
    logic [1:0]    prev_valid = 2'b00, cap_valid = 2'b00;
    logic [DW-1:0] cap_t = '0;
    logic          cap_err = 1'b0;
    logic [D-1:0]  dig [0:IT];
    logic [1:0]    gseq [$];
    logic [1:0]    rseq [$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        logic w;
        if (!rst_n) begin
            m_active = 1'b0; m_resp = 1'b0; m_prio = 1'b0; m_owner = 1'b0;
        end else if (!m_active) begin
            if (req != 2'b00) begin
                w = (req == 2'b11) ? m_prio : req[1];
                m_prio = ~w; m_owner = w; m_active = 1'b1; m_resp = 1'b0;
                m_got = 1'b0; m_age = 0;
                m_a = w ? a1 : a0; m_g = w ? g1 : g0; m_b = w ? b1 : b0;
            end
        end else if (m_resp) begin
            if (rsp_ready[m_owner]) m_active = 1'b0;
        end else begin
            if (core_done && !m_got) begin m_got = 1'b1; m_t = core_t; end
            if (m_age >= IT && m_got) begin
                m_resp = 1'b1; m_err = 1'b0;
            end else if (m_age == IT + TO) begin
                m_resp = 1'b1; m_err = 1'b1; m_t = '0;
            end
            m_age++;
        end
    endtask

    task automatic model_cmp();
        logic [1:0]   oh;
        logic         feeding;
        logic [D-1:0] e_b;
        oh = m_owner ? 2'b10 : 2'b01;
        feeding = m_active && !m_resp && (m_age <= IT);
        e_b = feeding ? m_b[BW-1-m_age*D -: D] : '0;
        chk("gnt", gnt_o, (feeding && m_age == 0) ? oh : 2'b00);
        chk("core_start", core_start_o, feeding && m_age == 0);
        chk("busy", busy_o, m_active);
        chk("core_b", core_b_o, e_b);
        chk("core_a", core_a_o, m_active ? m_a : '0);
        chk("core_g", core_g_o, m_active ? m_g : '0);
        chk("rsp_valid", rsp_valid_o, (m_active && m_resp) ? oh : 2'b00);
        if (m_active && m_resp) begin
            chk("rsp_t", rsp_t_o, m_t);
            chk("rsp_err", rsp_err_o, m_err);
        end
    endtask

    task automatic drive_req();
        req = {req_left[1] > 0, req_left[0] > 0};
    endtask

    // One clock: model and compare after the rising edge, bench stimulus on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_cmp();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (gnt_o[i]) begin
                gcnt++;
                if (req_left[i] > 0) req_left[i]--;
            end
        end
        if (gnt_o != 2'b00) gseq.push_back(gnt_o);
        drive_req();
        if (core_start_o) start_cnt++;
        if (core_start_o) stub_age = 0;
        else if (stub_age >= 0) stub_age++;
        if (stub_age >= 0 && stub_age <= IT) dig[stub_age] = core_b_o;
        core_done = (stub_age >= 0) && (stub_age == stub_target);
        if (core_done) core_t = stub_t;
        if (rsp_valid_o != 2'b00 && prev_valid == 2'b00) begin
            rseq.push_back(rsp_valid_o);
            rsp_age = stub_age;
            cap_valid = rsp_valid_o; cap_t = rsp_t_o; cap_err = rsp_err_o;
        end
        prev_valid = rsp_valid_o;
        rsp_ready = auto_ready ? rsp_valid_o : man_ready;
    endtask

    task automatic wait_rsp(input int lim);
        int n = 0;
        while (rsp_valid_o == 2'b00 && n < lim) begin tick(); n++; end
        chk("rsp_arrives", rsp_valid_o != 2'b00, 1'b1);
    endtask

    task automatic clear_logs();
        gcnt = 0; start_cnt = 0; rsp_age = -1; cap_valid = '0; cap_t = '0; cap_err = 1'b0;
        stub_age = -1;
        gseq.delete(); rseq.delete();
        for (int k = 0; k <= IT; k++) dig[k] = '0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    endtask

    initial begin
        logic [1:0]    exp_seq [3];
        logic [DW-1:0] st2;
        int            n;
        exp_seq = '{2'b01, 2'b10, 2'b01};
        a0 = '0; a0[DW-1] = 1'b1; a0[31:0] = 32'hA5A5_0001;
        g0 = '0; g0[DW-1] = 1'b1; g0[7:0] = 8'hC9;
        a1 = '0; a1[95:64] = 32'h5A5A_1111;
        g1 = '0; g1[DW-1] = 1'b1; g1[7:0] = 8'h93;
        for (int k = 0; k <= IT; k++) begin
            b0[BW-1-k*D -: D] = D'(k + 1);
            b1[BW-1-k*D -: D] = D'(16'h1000 + k);
        end
        stub_t = '0; stub_t[DW-1] = 1'b1; stub_t[63:0] = 64'hDEAD_BEEF_0123_4567;
        st2 = '0; st2[100:69] = 32'h1357_9BDF;
        clear_logs();

        // Reset state.
        tick(); tick();
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid_o, 2'b00);
        chk("rst_rsp_t", rsp_t_o, '0);
        chk("rst_core_b", core_b_o, '0);
        rst_n = 1'b1;
        tick();

        // Single request, core done 3 cycles after the last digit.
        clear_logs(); stub_target = IT + 3;
        req_left[0] = 1; drive_req();
        wait_rsp(100);
        chk("t1_valid", cap_valid, 2'b01);
        chk("t1_rsp_t", cap_t, stub_t);
        chk("t1_err", cap_err, 1'b0);
        chk("t1_latency", rsp_age, 14);
        chk("t1_gnt_cycles", gcnt, 1);
        chk("t1_start_cycles", start_cnt, 1);
        for (int k = 0; k <= IT; k++) chk("t1_digit", dig[k], D'(k + 1));
        repeat (3) tick();

        // Both requesters from reset: round-robin order 0, 1, 0.
        reset_pulse(); clear_logs(); stub_target = IT + 3;
        req_left[0] = 2; req_left[1] = 1; drive_req();
        n = 0;
        while (rseq.size() < 3 && n < 400) begin tick(); n++; end
        chk("t2_grants", gseq.size(), 3);
        chk("t2_rsps", rseq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_gnt_order", (i < gseq.size()) ? gseq[i] : 2'b00, exp_seq[i]);
            chk("t2_rsp_order", (i < rseq.size()) ? rseq[i] : 2'b00, exp_seq[i]);
        end
        repeat (3) tick();

        // Core never completes: timeout response.
        clear_logs(); stub_target = -1;
        req_left[0] = 1; drive_req();
        wait_rsp(200);
        chk("t3_latency", rsp_age, IT + 1 + TO);
        chk("t3_err", cap_err, 1'b1);
        chk("t3_rsp_t", cap_t, '0);
        repeat (2) tick();

        // Held response with a pending request from the other side.
        clear_logs(); stub_target = IT + 3; auto_ready = 1'b0; man_ready = 2'b00;
        req_left[0] = 1; drive_req();
        wait_rsp(100);
        req_left[1] = 1; drive_req(); gcnt = 0;
        repeat (20) begin
            tick();
            chk("t4_hold_valid", rsp_valid_o, 2'b01);
            chk("t4_hold_t", rsp_t_o, stub_t);
        end
        chk("t4_no_grant", gcnt, 0);
        man_ready = 2'b10; tick(); man_ready = 2'b00; tick();
        chk("t4_other_ready_ignored", rsp_valid_o, 2'b01);
        man_ready = 2'b01; tick(); man_ready = 2'b00; tick();
        chk("t4_released", rsp_valid_o, 2'b00);
        chk("t4_no_gnt_exit", gnt_o, 2'b00);
        tick();
        chk("t4_gnt1", gnt_o, 2'b10);
        auto_ready = 1'b1;
        wait_rsp(100);
        chk("t4_rsp1", cap_valid, 2'b10);
        repeat (3) tick();

        // Reset during feed cycle 5, then a clean retry.
        clear_logs(); stub_target = IT + 3;
        req_left[0] = 1; drive_req();
        n = 0;
        while (stub_age != 5 && n < 30) begin tick(); n++; end
        chk("t5_reached_feed5", stub_age, 5);
        rst_n = 1'b0;
        #1;
        chk("t5_gnt", gnt_o, 2'b00);
        chk("t5_busy", busy_o, 1'b0);
        chk("t5_core_start", core_start_o, 1'b0);
        chk("t5_core_b", core_b_o, '0);
        chk("t5_core_a", core_a_o, '0);
        chk("t5_core_g", core_g_o, '0);
        chk("t5_rsp_valid", rsp_valid_o, 2'b00);
        tick();
        rst_n = 1'b1; clear_logs();
        req_left[0] = 1; drive_req();
        wait_rsp(100);
        chk("t5_digit0", dig[0], 16'h0001);
        chk("t5_digit10", dig[IT], 16'h000B);
        chk("t5_latency", rsp_age, 14);
        chk("t5_valid", cap_valid, 2'b01);
        repeat (3) tick();

        // Completion during the last feed cycle, then during an earlier one.
        clear_logs(); stub_target = IT;
        req_left[1] = 1; drive_req();
        wait_rsp(100);
        chk("t6_latency", rsp_age, IT + 1);
        chk("t6_valid", cap_valid, 2'b10);
        chk("t6_rsp_t", cap_t, stub_t);
        chk("t6_err", cap_err, 1'b0);
        repeat (3) tick();
        clear_logs(); stub_target = 4; stub_t = st2;
        req_left[0] = 1; drive_req();
        wait_rsp(100);
        chk("t6b_latency", rsp_age, IT + 1);
        chk("t6b_rsp_t", cap_t, st2);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
